// File: rtl/slot_credit_ctrl.sv
// Credit/play controller for a slot-machine mode core: takes coins, bets, times the spin, pays out wins.
// Optional SLOT_JACKPOT_EN macro enables a jackpot payout when spin_out matches JACKPOT_VALUE.
module slot_credit_ctrl #(
  parameter int unsigned CW            = 8,
  parameter int unsigned BET           = 1,
  parameter int unsigned PAY_WIN       = 10,
  parameter int unsigned PAY_JACKPOT   = 100,
  parameter int unsigned JACKPOT_VALUE = 777,
  parameter int unsigned HOLD_CYCLES   = 16,
  parameter int unsigned SETTLE_CYCLES = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          coin,
  input  logic          play,
  input  logic [9:0]    spin_out,
  input  logic          spin_won,
  output logic          start,
  output logic [CW-1:0] credits,
  output logic          busy,
  output logic          win_flag,
  output logic [9:0]    last_out
);

  localparam int unsigned TMAX = (HOLD_CYCLES > SETTLE_CYCLES) ? HOLD_CYCLES : SETTLE_CYCLES;
  localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  // Arithmetic width with headroom so coin + payout never wraps before saturation.
  localparam int unsigned SW   = CW + 16;
  localparam logic [SW-1:0] CMAX = SW'({CW{1'b1}});

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SPIN   = 2'd1,
    SETTLE = 2'd2,
    EVAL   = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [CW-1:0] credits_q, credits_d;
  logic          start_q, start_d;
  logic          busy_q, busy_d;
  logic          win_flag_q, win_flag_d;
  logic [9:0]    last_out_q, last_out_d;

  logic          bet_c;
  logic [SW-1:0] pay_c;
  logic [SW-1:0] sum_c;
  logic [SW-1:0] win_pay_c;

`ifdef SLOT_JACKPOT_EN
  assign win_pay_c = (spin_out == 10'(JACKPOT_VALUE)) ? SW'(PAY_JACKPOT) : SW'(PAY_WIN);
`else
  logic unused_jackpot_c;
  assign win_pay_c        = SW'(PAY_WIN);
  assign unused_jackpot_c = ^{JACKPOT_VALUE, PAY_JACKPOT};
`endif

  // Next-state, timer, credit arithmetic and output decode.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    win_flag_d = win_flag_q;
    last_out_d = last_out_q;
    bet_c      = 1'b0;
    pay_c      = '0;

    case (state_q)
      IDLE: begin
        // Guard uses the registered balance, so a same-cycle coin cannot fund the bet.
        if (play && (SW'(credits_q) >= SW'(BET))) begin
          state_d    = SPIN;
          timer_d    = TW'(HOLD_CYCLES - 1);
          win_flag_d = 1'b0;
          bet_c      = 1'b1;
        end
      end
      SPIN: begin
        if (timer_q == '0) begin
          state_d = SETTLE;
          timer_d = TW'(SETTLE_CYCLES - 1);
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      SETTLE: begin
        if (timer_q == '0) begin
          state_d = EVAL;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      EVAL: begin
        state_d    = IDLE;
        last_out_d = spin_out;
        win_flag_d = spin_won;
        if (spin_won) begin
          pay_c = win_pay_c;
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase

    sum_c     = SW'(credits_q) + SW'(coin) + pay_c - (bet_c ? SW'(BET) : SW'(0));
    credits_d = (sum_c > CMAX) ? CW'(CMAX) : CW'(sum_c);
    start_d   = (state_d == SPIN);
    busy_d    = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      credits_q  <= '0;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
      win_flag_q <= 1'b0;
      last_out_q <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      credits_q  <= credits_d;
      start_q    <= start_d;
      busy_q     <= busy_d;
      win_flag_q <= win_flag_d;
      last_out_q <= last_out_d;
    end
  end

  assign start    = start_q;
  assign credits  = credits_q;
  assign busy     = busy_q;
  assign win_flag = win_flag_q;
  assign last_out = last_out_q;

endmodule

// File: tb/tb_slot_credit_ctrl.sv
// Directed bench for slot_credit_ctrl with default parameters.
module tb_slot_credit_ctrl;

  logic       clk;
  logic       rst;
  logic       coin;
  logic       play;
  logic [9:0] spin_out;
  logic       spin_won;
  logic       start;
  logic [7:0] credits;
  logic       busy;
  logic       win_flag;
  logic [9:0] last_out;

  int n_checks = 0;
  int n_fail   = 0;

  slot_credit_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .coin     (coin),
    .play     (play),
    .spin_out (spin_out),
    .spin_won (spin_won),
    .start    (start),
    .credits  (credits),
    .busy     (busy),
    .win_flag (win_flag),
    .last_out (last_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // One full play from the accepting edge to the first IDLE cycle after EVAL.
  task automatic do_play(input string tag, input logic won, input logic [9:0] outv,
                         input int exp_bet, input int exp_final, input logic exp_wf,
                         input logic replay, input logic coin_eval);
    int hi;
    int errs;
    hi   = 0;
    errs = 0;
    play = 1'b1;
    tick();
    play     = 1'b0;
    spin_won = ~won;
    spin_out = ~outv;
    chk({tag, "_credits_bet"}, 32'(credits), 32'(exp_bet));
    chk({tag, "_wf_cleared"}, 32'(win_flag), 32'd0);
    chk({tag, "_busy_spin"}, 32'(busy), 32'd1);
    for (int i = 0; i < 24; i++) begin
      if (start !== (i < 16)) errs++;
      if (start === 1'b1) hi++;
      play = (replay && (i == 4));
      tick();
    end
    play     = 1'b0;
    spin_won = won;
    spin_out = outv;
    coin     = coin_eval;
    chk({tag, "_start_pattern_errs"}, 32'(errs), 32'd0);
    chk({tag, "_start_hi_cycles"}, 32'(hi), 32'd16);
    chk({tag, "_busy_eval"}, 32'(busy), 32'd1);
    chk({tag, "_start_eval"}, 32'(start), 32'd0);
    tick();
    coin = 1'b0;
    chk({tag, "_busy_done"}, 32'(busy), 32'd0);
    chk({tag, "_credits_final"}, 32'(credits), 32'(exp_final));
    chk({tag, "_win_flag"}, 32'(win_flag), 32'(exp_wf));
    chk({tag, "_last_out"}, 32'(last_out), 32'(outv));
  endtask

  initial begin
    int starts;
    rst      = 1'b0;
    coin     = 1'b0;
    play     = 1'b0;
    spin_out = 10'd0;
    spin_won = 1'b0;
    tick();
    tick();
    chk("rst_start", 32'(start), 32'd0);
    chk("rst_credits", 32'(credits), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_win_flag", 32'(win_flag), 32'd0);
    chk("rst_last_out", 32'(last_out), 32'd0);
    rst = 1'b1;
    tick();

    coin = 1'b1;
    tick();
    tick();
    tick();
    coin = 1'b0;
    chk("coins_3", 32'(credits), 32'd3);

    do_play("first", 1'b0, 10'd100, 2, 2, 1'b0, 1'b0, 1'b0);
    do_play("lose", 1'b0, 10'd123, 1, 1, 1'b0, 1'b0, 1'b0);
    do_play("win", 1'b1, 10'd456, 0, 10, 1'b1, 1'b0, 1'b0);
    do_play("replay", 1'b0, 10'd5, 9, 9, 1'b0, 1'b1, 1'b0);

    starts = 0;
    for (int i = 0; i < 5; i++) begin
      if (start !== 1'b0 || busy !== 1'b0) starts++;
      tick();
    end
    chk("no_second_spin", 32'(starts), 32'd0);
    chk("credits_after_replay", 32'(credits), 32'd9);

    // Reset in the middle of SPIN.
    play = 1'b1;
    tick();
    play = 1'b0;
    chk("mid_credits_bet", 32'(credits), 32'd8);
    tick();
    tick();
    tick();
    #2;
    rst = 1'b0;
    #1;
    chk("async_start", 32'(start), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_credits", 32'(credits), 32'd0);
    tick();
    rst = 1'b1;
    tick();

    coin = 1'b1;
    play = 1'b1;
    tick();
    coin = 1'b0;
    play = 1'b0;
    chk("coinplay_credits", 32'(credits), 32'd1);
    starts = 0;
    for (int i = 0; i < 4; i++) begin
      if (start !== 1'b0 || busy !== 1'b0) starts++;
      tick();
    end
    chk("coinplay_no_spin", 32'(starts), 32'd0);

    do_play("post_rst", 1'b1, 10'd300, 0, 10, 1'b1, 1'b0, 1'b0);

    coin = 1'b1;
    for (int i = 0; i < 240; i++) tick();
    coin = 1'b0;
    chk("credits_250", 32'(credits), 32'd250);
    do_play("sat", 1'b1, 10'd55, 249, 255, 1'b1, 1'b0, 1'b1);
    coin = 1'b1;
    tick();
    coin = 1'b0;
    chk("sat_coin", 32'(credits), 32'd255);

    rst = 1'b0;
    tick();
    rst = 1'b1;
    coin = 1'b1;
    tick();
    coin = 1'b0;
    chk("jp_coin", 32'(credits), 32'd1);
`ifdef SLOT_JACKPOT_EN
    do_play("jackpot", 1'b1, 10'd777, 0, 100, 1'b1, 1'b0, 1'b0);
`else
    do_play("jackpot", 1'b1, 10'd777, 0, 10, 1'b1, 1'b0, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/slot_credit_ctrl.md
# slot_credit_ctrl

Credit and play controller that drives the `start` input of a slot-machine mode core (e.g. `mode2`) and consumes its `out[9:0]` / `won` result. It accepts coin pulses, deducts a bet when a play is requested, holds `start` high for a fixed spin time, waits for the reels to settle, then samples the result and credits winnings. It sits between the player-input debouncers and the mode core, and feeds the credit and result displays.

## Interface
Parameters:
- `CW`, 8, credit counter width; maximum credit CMAX = 2^CW−1
- `BET`, 1, credits deducted per play
- `PAY_WIN`, 10, credits added when `spin_won`=1
- `PAY_JACKPOT`, 100, credits added on jackpot (only with the `SLOT_JACKPOT_EN` macro)
- `JACKPOT_VALUE`, 777, `spin_out` value treated as jackpot
- `HOLD_CYCLES`, 16, cycles `start` is held high (≥1)
- `SETTLE_CYCLES`, 8, cycles waited after `start` falls before sampling (≥1)

Ports:
- `clk`  in  1  system clock, rising-edge
- `rst`  in  1  reset, asynchronous assert, active-low
- `coin`  in  1  one-cycle pulse; adds 1 credit
- `play`  in  1  one-cycle pulse; play request
- `spin_out`  in  10  mode-core result value
- `spin_won`  in  1  mode-core win flag (level)
- `start`  out  1  spin request to the mode core
- `credits`  out  CW  current credit balance
- `busy`  out  1  high in every state except IDLE
- `win_flag`  out  1  last play was a win; cleared on the next accepted play
- `last_out`  out  10  `spin_out` captured at the last EVAL

## Operation
- States: IDLE, SPIN, SETTLE, EVAL.
- IDLE: `busy`=0. If `play`=1 and registered `credits` ≥ BET, then `credits` −= BET, `win_flag` clears, the timer loads, and the next state is SPIN. If `play`=1 and `credits` < BET, the request is ignored and the state stays IDLE.
- SPIN: `start`=1 for exactly HOLD_CYCLES cycles, then SETTLE.
- SETTLE: `start`=0 for exactly SETTLE_CYCLES cycles, then EVAL.
- EVAL: one cycle. Sample `spin_out` → `last_out` and `spin_won` → `win_flag`. If won, add PAY_WIN to `credits`. Return to IDLE.
- `coin` is accepted in every state. It adds 1 in the same cycle as any bet deduction or payout, so the net update is coin + payout − bet.
- All credit additions saturate at CMAX; no wrap. Deduction never underflows, because the guard uses the pre-update value.
- `play` outside IDLE is ignored; it is not queued.
- `play` and `coin` in the same IDLE cycle: the guard uses the pre-coin balance. Example: credits=0, coin+play gives credits=1 and no spin.

## Timing
- Reset values: state IDLE, `start`=0, `credits`=0, `busy`=0, `win_flag`=0, `last_out`=0, timer=0.
- Reset mid-operation returns immediately to IDLE. `start` drops asynchronously. The deducted bet is not refunded.
- `play` accepted at edge N:
  - `start`=1 from cycle N+1 to N+HOLD_CYCLES.
  - EVAL is at cycle N+HOLD_CYCLES+SETTLE_CYCLES+1.
  - Payout, `win_flag` and `last_out` are visible from cycle N+HOLD_CYCLES+SETTLE_CYCLES+2. With defaults this is N+26.
- Credit changes are visible one cycle after the causing edge.
- `spin_won`/`spin_out` are sampled only in EVAL; values at other times are don't-care.
- The earliest next play is accepted in the first IDLE cycle after EVAL.

## Configuration
- `SLOT_JACKPOT_EN` defined: in EVAL, if `spin_won`=1 and `spin_out`==JACKPOT_VALUE, add PAY_JACKPOT instead of PAY_WIN (saturating). All other wins pay PAY_WIN.
- `SLOT_JACKPOT_EN` undefined: the jackpot comparator is absent and every win pays PAY_WIN. PAY_JACKPOT and JACKPOT_VALUE are unused.

## Test plan
- Reset, then 3 `coin` pulses, then `play`. Require `credits` 3→2, `start` high for exactly 16 cycles, low for 8, `busy` low again at cycle N+26.
- Losing play: `credits`=2, `spin_won`=0, `spin_out`=123 at EVAL. Require `credits`=1, `win_flag`=0, `last_out`=123.
- Winning play: `credits`=1, `spin_won`=1, `spin_out`=456. Require `credits`=10 (1−1+10), `win_flag`=1, `last_out`=456. With `SLOT_JACKPOT_EN` and `spin_out`=777, require `credits`=100.
- Zero credits with `coin`+`play` in the same cycle: require `credits`=1, no `start`. `play` during SPIN is ignored, with exactly one spin observed.
- Saturation: `credits`=250 and a win with coin in EVAL. Require `credits`=255, not a wrapped value.
- Drive `rst`=0 mid-SPIN: require `start`=0 immediately, IDLE state, `credits`=0, and normal operation after release.
